// File: rtl/pixel_depth_writer_pkg.sv
// Shared types for the pixel depth writer: fixed-point formats, RGBA8888 layout and FSM states.
// PIXEL_WRITER_DEPTH_TEST_EN adds the READ/CMP states used by the z-buffer test.
package pixel_depth_writer_pkg;

    localparam int FRAC_BITS = 16;

    typedef logic signed [31:0] FixedPoint_t;

    localparam FixedPoint_t FIX_ONE = FixedPoint_t'(1 << FRAC_BITS);

    typedef struct packed {
        FixedPoint_t r;
        FixedPoint_t g;
        FixedPoint_t b;
        FixedPoint_t a;
    } Vector4_t;

    localparam logic [31:0] Z_FAR = 32'h7FFF_FFFF;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic [7:0] a;
    } rgba8888_t;

    localparam int RGBA_R_LSB = 24;
    localparam int RGBA_G_LSB = 16;
    localparam int RGBA_B_LSB = 8;
    localparam int RGBA_A_LSB = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
`ifdef PIXEL_WRITER_DEPTH_TEST_EN
        ST_READ,
        ST_CMP,
`endif
        ST_WRITE,
        ST_CLEAR
    } state_e;

endpackage

// File: rtl/pixel_depth_writer_if.sv
// Rasterizer-to-writer pixel stream: pixel payload, valid/ready handshake and clear request.
// Signal names keep the writer's point of view (i_ = into the writer, o_ = out of it).
interface pixel_depth_writer_if;
    import pixel_depth_writer_pkg::*;

    logic               i_valid;
    logic               o_ready;
    logic signed [31:0] i_x;
    logic signed [31:0] i_y;
    FixedPoint_t        i_z;
    Vector4_t           i_colour;
    logic               i_clear;

    modport master (
        output i_valid, i_x, i_y, i_z, i_colour, i_clear,
        input  o_ready
    );

    modport slave (
        input  i_valid, i_x, i_y, i_z, i_colour, i_clear,
        output o_ready
    );

endinterface

// File: rtl/pixel_depth_writer_colour_pack_rgba8888.sv
// Combinational FixedPoint RGBA -> RGBA8888 packer with per-channel clamp to [0,255].
module pixel_depth_writer_colour_pack_rgba8888
    import pixel_depth_writer_pkg::*;
(
    input  Vector4_t    i_colour,
    output logic [31:0] o_rgba
);

    // Channels in (0,1.0) scale by 255 and truncate; out-of-range values saturate.
    function automatic logic [7:0] sat_chan(input FixedPoint_t c);
        if (c <= 0) begin
            return 8'd0;
        end
        if (c >= FIX_ONE) begin
            return 8'd255;
        end
        return 8'(($unsigned(c) * 32'd255) >> FRAC_BITS);
    endfunction

    always_comb begin
        o_rgba                   = '0;
        o_rgba[RGBA_R_LSB +: 8]  = sat_chan(i_colour.r);
        o_rgba[RGBA_G_LSB +: 8]  = sat_chan(i_colour.g);
        o_rgba[RGBA_B_LSB +: 8]  = sat_chan(i_colour.b);
        o_rgba[RGBA_A_LSB +: 8]  = sat_chan(i_colour.a);
    end

endmodule

// File: rtl/pixel_depth_writer.sv
// Depth-tested pixel writer between the rasterizer and the frame/depth memories, with clear sweep.
// Define PIXEL_WRITER_DEPTH_TEST_EN for the z-buffer read/compare path; otherwise every in-bounds pixel commits.
module pixel_depth_writer
    import pixel_depth_writer_pkg::*;
#(
    parameter int          WIDTH        = 16,
    parameter int          HEIGHT       = 16,
    parameter int          ADDR_W       = 8,
    parameter logic [31:0] CLEAR_COLOUR = 32'h0000_00FF
) (
    input  logic                i_clk,
    input  logic                i_reset_n,
    pixel_depth_writer_if.slave bus,
    output logic [ADDR_W-1:0]   o_zb_addr,
    output logic                o_zb_re,
    input  logic [31:0]         i_zb_rdata,
    output logic                o_zb_we,
    output logic [31:0]         o_zb_wdata,
    output logic [ADDR_W-1:0]   o_fb_addr,
    output logic                o_fb_we,
    output logic [31:0]         o_fb_wdata,
    output logic [31:0]         o_written,
    output logic [31:0]         o_rejected
);

    localparam int NPIX = WIDTH * HEIGHT;

    state_e              r_state;
    state_e              w_state_nxt;
    logic [ADDR_W-1:0]   r_addr_p0;
    FixedPoint_t         r_z_p0;
    logic [31:0]         r_rgba_p0;
    logic                r_pass;
    logic [ADDR_W-1:0]   r_clr_addr;
    logic [31:0]         r_written;
    logic [31:0]         r_rejected;

    logic                w_accept;
    logic                w_in_bounds;
    logic [ADDR_W-1:0]   w_addr;
    logic [31:0]         w_rgba;

    pixel_depth_writer_colour_pack_rgba8888 u_pack (
        .i_colour (bus.i_colour),
        .o_rgba   (w_rgba)
    );

    assign bus.o_ready = (r_state == ST_IDLE) && !bus.i_clear;
    assign w_accept    = bus.i_valid && bus.o_ready;
    assign w_in_bounds = (bus.i_x >= 0) && (bus.i_x < WIDTH) &&
                         (bus.i_y >= 0) && (bus.i_y < HEIGHT);
    assign w_addr      = ADDR_W'(bus.i_y * WIDTH + bus.i_x);

`ifndef PIXEL_WRITER_DEPTH_TEST_EN
    logic w_unused_rdata;
    assign w_unused_rdata = ^i_zb_rdata;
`endif

    always_comb begin
        w_state_nxt = r_state;
        o_zb_re     = 1'b0;
        o_zb_we     = 1'b0;
        o_fb_we     = 1'b0;
        o_zb_addr   = '0;
        o_fb_addr   = '0;
        o_zb_wdata  = '0;
        o_fb_wdata  = '0;
        case (r_state)
            ST_IDLE: begin
                if (bus.i_clear) begin
                    w_state_nxt = ST_CLEAR;
                end else if (bus.i_valid) begin
`ifdef PIXEL_WRITER_DEPTH_TEST_EN
                    w_state_nxt = w_in_bounds ? ST_READ : ST_WRITE;
`else
                    w_state_nxt = ST_WRITE;
`endif
                end
            end
`ifdef PIXEL_WRITER_DEPTH_TEST_EN
            ST_READ: begin
                o_zb_re     = 1'b1;
                o_zb_addr   = r_addr_p0;
                w_state_nxt = ST_CMP;
            end
            ST_CMP: begin
                w_state_nxt = ST_WRITE;
            end
`endif
            ST_WRITE: begin
                o_zb_we     = r_pass;
                o_fb_we     = r_pass;
                o_zb_addr   = r_addr_p0;
                o_fb_addr   = r_addr_p0;
                o_zb_wdata  = r_z_p0;
                o_fb_wdata  = r_rgba_p0;
                w_state_nxt = ST_IDLE;
            end
            ST_CLEAR: begin
                o_zb_we    = 1'b1;
                o_fb_we    = 1'b1;
                o_zb_addr  = r_clr_addr;
                o_fb_addr  = r_clr_addr;
                o_zb_wdata = Z_FAR;
                o_fb_wdata = CLEAR_COLOUR;
                if (r_clr_addr == ADDR_W'(NPIX - 1)) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Stage p0: pixel payload captured on accept; only meaningful while the FSM is busy.
    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            r_addr_p0 <= w_addr;
            r_z_p0    <= bus.i_z;
            r_rgba_p0 <= w_rgba;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state    <= ST_IDLE;
            r_pass     <= 1'b0;
            r_clr_addr <= '0;
            r_written  <= '0;
            r_rejected <= '0;
        end else begin
            r_state <= w_state_nxt;
            // Out-of-bounds pixels carry pass=0 straight to WRITE so they are counted there.
            if (w_accept) begin
                r_pass <= w_in_bounds;
            end
`ifdef PIXEL_WRITER_DEPTH_TEST_EN
            if (r_state == ST_CMP) begin
                r_pass <= r_z_p0 < $signed(i_zb_rdata);
            end
`endif
            if (r_state == ST_WRITE) begin
                if (r_pass) begin
                    r_written <= r_written + 32'd1;
                end else begin
                    r_rejected <= r_rejected + 32'd1;
                end
            end
            if (r_state == ST_IDLE) begin
                r_clr_addr <= '0;
            end else if (r_state == ST_CLEAR) begin
                r_clr_addr <= r_clr_addr + 1'b1;
            end
        end
    end

    assign o_written  = r_written;
    assign o_rejected = r_rejected;

endmodule

// File: tb/tb_pixel_depth_writer.sv
// Directed bench for pixel_depth_writer on a 4x4 framebuffer with a write scoreboard.
// Expectations adapt to PIXEL_WRITER_DEPTH_TEST_EN being defined or not.
module tb_pixel_depth_writer;
    import pixel_depth_writer_pkg::*;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int AW = 4;
`ifdef PIXEL_WRITER_DEPTH_TEST_EN
    localparam bit DEPTH     = 1'b1;
    localparam int LAT       = 3;
    localparam int RST_EDGES = 2;
`else
    localparam bit DEPTH     = 1'b0;
    localparam int LAT       = 1;
    localparam int RST_EDGES = 1;
`endif

    logic          clk;
    logic          rst_n;
    logic [AW-1:0] zb_addr;
    logic          zb_re;
    logic [31:0]   zb_rdata;
    logic          zb_we;
    logic [31:0]   zb_wdata;
    logic [AW-1:0] fb_addr;
    logic          fb_we;
    logic [31:0]   fb_wdata;
    logic [31:0]   written;
    logic [31:0]   rejected;

    pixel_depth_writer_if bus ();

    pixel_depth_writer #(
        .WIDTH        (W),
        .HEIGHT       (H),
        .ADDR_W       (AW),
        .CLEAR_COLOUR (32'h0000_00FF)
    ) dut (
        .i_clk      (clk),
        .i_reset_n  (rst_n),
        .bus        (bus),
        .o_zb_addr  (zb_addr),
        .o_zb_re    (zb_re),
        .i_zb_rdata (zb_rdata),
        .o_zb_we    (zb_we),
        .o_zb_wdata (zb_wdata),
        .o_fb_addr  (fb_addr),
        .o_fb_we    (fb_we),
        .o_fb_wdata (fb_wdata),
        .o_written  (written),
        .o_rejected (rejected)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   rgba;
        logic [31:0]   z;
        int            due;
    } exp_t;

    exp_t               q[$];
    exp_t               e;
    logic signed [31:0] zmodel [16];
    logic [31:0]        zmem [16];
    int                 ncyc = 0;
    int                 n_vec = 0;
    int                 n_err = 0;
    int                 exp_written = 0;
    int                 exp_rejected = 0;

    always @(posedge clk) ncyc <= ncyc + 1;

    // Synchronous-read z-buffer RAM, data valid one cycle after read enable.
    always @(posedge clk) begin
        if (zb_re) zb_rdata <= zmem[zb_addr];
        if (zb_we) zmem[zb_addr] <= zb_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        assert (got === want) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && (fb_we || zb_we)) begin
            if (q.size() == 0) begin
                chk("unexpected_write", {30'd0, fb_we, zb_we}, 32'd0);
            end else begin
                e = q.pop_front();
                chk("fb_we", 32'(fb_we), 32'd1);
                chk("zb_we", 32'(zb_we), 32'd1);
                chk("fb_addr", 32'(fb_addr), 32'(e.addr));
                chk("zb_addr", 32'(zb_addr), 32'(e.addr));
                chk("fb_wdata", fb_wdata, e.rgba);
                chk("zb_wdata", zb_wdata, e.z);
                chk("write_cycle", 32'(ncyc), 32'(e.due));
            end
        end
    end

    function automatic Vector4_t mkcol(input logic [31:0] r, input logic [31:0] g,
                                       input logic [31:0] b, input logic [31:0] a);
        Vector4_t v;
        v.r = r; v.g = g; v.b = b; v.a = a;
        return v;
    endfunction

    task automatic do_clear();
        int k0;
        exp_t t;
        bus.i_clear = 1'b1;
        #1;
        chk("ready_on_clear", 32'(bus.o_ready), 32'd0);
        k0 = ncyc;
        for (int i = 0; i < W * H; i++) begin
            t.addr = AW'(i); t.rgba = 32'h0000_00FF; t.z = 32'h7FFF_FFFF; t.due = k0 + 1 + i;
            q.push_back(t);
            zmodel[i] = 32'h7FFF_FFFF;
        end
        @(posedge clk);
        @(negedge clk);
        bus.i_clear = 1'b0;
        chk("ready_during_clear", 32'(bus.o_ready), 32'd0);
        repeat (W * H) @(negedge clk);
        chk("ready_after_clear", 32'(bus.o_ready), 32'd1);
    endtask

    task automatic send_pixel(input int x, input int y, input logic [31:0] z,
                              input Vector4_t c, input logic [31:0] rgba);
        bit            inb;
        bit            pass;
        int            k;
        int            acc;
        logic [AW-1:0] addr;
        exp_t          t;
        bus.i_valid = 1'b1; bus.i_x = x; bus.i_y = y; bus.i_z = z; bus.i_colour = c;
        #1;
        k = 0;
        while (!bus.o_ready && k < 200) begin @(negedge clk); #1; k++; end
        chk("accept_ready", 32'(bus.o_ready), 32'd1);
        if (!bus.o_ready) begin
            bus.i_valid = 1'b0;
            return;
        end
        acc  = ncyc;
        inb  = (x >= 0) && (x < W) && (y >= 0) && (y < H);
        addr = AW'(y * W + x);
        pass = inb && (!DEPTH || ($signed(z) < zmodel[addr]));
        if (pass) begin
            t.addr = addr; t.rgba = rgba; t.z = z; t.due = acc + LAT;
            q.push_back(t);
            zmodel[addr] = z;
            exp_written++;
        end else begin
            exp_rejected++;
        end
        @(posedge clk);
        @(negedge clk);
        bus.i_valid = 1'b0;
        chk("zb_re", 32'(zb_re), 32'(DEPTH && inb));
        chk("zb_re_addr", zb_re ? 32'(zb_addr) : 32'd0, (DEPTH && inb) ? 32'(addr) : 32'd0);
        k = 0;
        while (!bus.o_ready && k < 200) begin @(negedge clk); k++; end
        chk("busy_cycles", 32'(k), (DEPTH && inb) ? 32'd3 : 32'd1);
        chk("written", written, 32'(exp_written));
        chk("rejected", rejected, 32'(exp_rejected));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        bus.i_valid = 1'b0; bus.i_clear = 1'b0;
        bus.i_x = '0; bus.i_y = '0; bus.i_z = '0; bus.i_colour = '0;
        repeat (3) @(negedge clk);
        chk("rst_fb_we", 32'(fb_we), 32'd0);
        chk("rst_zb_we", 32'(zb_we), 32'd0);
        chk("rst_zb_re", 32'(zb_re), 32'd0);
        chk("rst_written", written, 32'd0);
        chk("rst_rejected", rejected, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        do_clear();
        send_pixel(1, 2, 32'h0000_8000, mkcol(32'h1_0000, 32'h8000, 32'h0, 32'h1_0000), 32'hFF7F_00FF);
        send_pixel(1, 2, 32'h0000_8000, mkcol(32'h1_0000, 32'h8000, 32'h0, 32'h1_0000), 32'hFF7F_00FF);
        send_pixel(1, 2, 32'h0000_C000, mkcol(32'h1_0000, 32'h8000, 32'h0, 32'h1_0000), 32'hFF7F_00FF);
        send_pixel(1, 2, 32'h0000_4000, mkcol(32'h1_0000, 32'h8000, 32'h0, 32'h1_0000), 32'hFF7F_00FF);
        send_pixel(-1, 0, 32'h0000_1000, mkcol(32'h1_0000, 32'h1_0000, 32'h1_0000, 32'h1_0000), 32'hFFFF_FFFF);
        send_pixel(0, 4, 32'h0000_1000, mkcol(32'h1_0000, 32'h1_0000, 32'h1_0000, 32'h1_0000), 32'hFFFF_FFFF);
        send_pixel(0, 0, 32'h0000_1000, mkcol(32'hFFFF_8000, 32'h2_0000, 32'h4000, 32'hFFFF), 32'h00FF_3FFE);
        send_pixel(0, 1, 32'hFFFF_0000, mkcol(32'h0, 32'h0, 32'h1_0000, 32'h8000), 32'h0000_FF7F);
        send_pixel(2, 1, 32'h0000_4000, mkcol(32'h8000, 32'h8000, 32'h8000, 32'h1_0000), 32'h7F7F_7FFF);
        send_pixel(2, 1, 32'h0000_C000, mkcol(32'h8000, 32'h8000, 32'h8000, 32'h1_0000), 32'h7F7F_7FFF);

        // Clear and pixel presented together: the clear runs first, the pixel waits.
        bus.i_valid = 1'b1; bus.i_x = 3; bus.i_y = 3; bus.i_z = 32'h0002_0000;
        bus.i_colour = mkcol(32'h1_0000, 32'h0, 32'h0, 32'h1_0000);
        do_clear();
        send_pixel(3, 3, 32'h0002_0000, mkcol(32'h1_0000, 32'h0, 32'h0, 32'h1_0000), 32'hFF00_00FF);

        // Reset while a pixel is in flight: it must vanish without a strobe.
        @(negedge clk);
        bus.i_valid = 1'b1; bus.i_x = 1; bus.i_y = 1; bus.i_z = 32'h0;
        bus.i_colour = mkcol(32'h1_0000, 32'h1_0000, 32'h1_0000, 32'h1_0000);
        #1;
        chk("ready_pre_reset", 32'(bus.o_ready), 32'd1);
        repeat (RST_EDGES) @(posedge clk);
        #1;
        rst_n = 1'b0;
        bus.i_valid = 1'b0;
        @(negedge clk);
        chk("midrst_fb_we", 32'(fb_we), 32'd0);
        chk("midrst_zb_we", 32'(zb_we), 32'd0);
        chk("midrst_written", written, 32'd0);
        chk("midrst_rejected", rejected, 32'd0);
        chk("midrst_ready", 32'(bus.o_ready), 32'd1);
        exp_written = 0;
        exp_rejected = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_pixel(3, 0, 32'h0, mkcol(32'h0, 32'h1_0000, 32'h0, 32'h1_0000), 32'h00FF_00FF);

        repeat (4) @(negedge clk);
        chk("scoreboard_empty", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
